// File: rtl/ir_command_sequencer.sv
// ir_command_sequencer: bus-mapped scheduler for the IR transmitter.
// It queues drive commands in a small FIFO and presents each one on CAR and
// CONTROL for a programmable number of packets. After the queue drains it
// sends exactly one stop packet.
module ir_command_sequencer #(
  parameter logic [7:0] BASE_ADDR  = 8'h90,
  // Power of two, 2..8. The pointers wrap by natural binary overflow.
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DUR_RESET  = 8'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic       PACKET_DONE,
  output logic [3:0] CAR,
  output logic [3:0] CONTROL,
  output logic       BUSY
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STOP   = 2'd2
  } state_t;

  state_t             state_q;
  logic [3:0]         car_q;
  logic [3:0]         control_q;
  logic [7:0]         remain_q;
  logic [7:0]         dur_q;
  logic               ovf_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [4:0]         mem_q [FIFO_DEPTH];

  logic       wr_cmd, wr_dur, wr_ctrl, rd_status, abort;
  logic       fifo_empty, fifo_full;
  logic       pop, push, ovf_set;
  logic [4:0] head;
  logic [7:0] load_dur;
  logic [7:0] count_ext;
  logic [7:0] status;

  // Direction code to {BACK, FWD, LEFT, RIGHT}; codes 0 and 7 mean stop.
  function automatic logic [3:0] dir_decode(input logic [2:0] code);
    case (code)
      3'd1:    return 4'b0100;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b0101;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  // Bus address decode.
  assign wr_cmd    = BUS_WE  && (BUS_ADDR == BASE_ADDR);
  assign wr_dur    = BUS_WE  && (BUS_ADDR == BASE_ADDR + 8'd1);
  assign wr_ctrl   = BUS_WE  && (BUS_ADDR == BASE_ADDR + 8'd2);
  assign rd_status = !BUS_WE && (BUS_ADDR == BASE_ADDR + 8'd2);
  assign abort     = wr_ctrl && BUS_DATA[0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign load_dur   = (dur_q == 8'd0) ? 8'd1 : dur_q;

  // A pop happens whenever the FSM loads a command: from IDLE, or at the last
  // packet of an active command when another one is waiting. ABORT wins.
  assign pop = !abort && !fifo_empty &&
               ((state_q == ST_IDLE) ||
                (state_q == ST_ACTIVE && PACKET_DONE && remain_q == 8'd1));

  // A full FIFO still accepts a write in the cycle it pops.
  assign push    = wr_cmd && !abort && (!fifo_full || pop);
  assign ovf_set = wr_cmd && !abort && fifo_full && !pop;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Command storage; only the low five bits of a command are meaningful.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= BUS_DATA[4:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Packets-per-command register; picked up at the next command load.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dur_q <= DUR_RESET;
    end else if (wr_dur) begin
      dur_q <= BUS_DATA;
    end
  end

  // Sequencer FSM with registered CAR/CONTROL and the packet countdown.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      car_q     <= 4'b0001;
      control_q <= 4'b0000;
      remain_q  <= 8'd0;
    end else if (abort) begin
      state_q   <= ST_STOP;
      control_q <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          control_q <= 4'b0000;
          if (pop) begin
            car_q     <= 4'b0001 << head[4:3];
            control_q <= dir_decode(head[2:0]);
            remain_q  <= load_dur;
            state_q   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (PACKET_DONE) begin
            if (remain_q == 8'd1) begin
              if (pop) begin
                car_q     <= 4'b0001 << head[4:3];
                control_q <= dir_decode(head[2:0]);
                remain_q  <= load_dur;
              end else begin
                control_q <= 4'b0000;
                state_q   <= ST_STOP;
              end
            end else begin
              remain_q <= remain_q - 8'd1;
            end
          end
        end
        ST_STOP: begin
          control_q <= 4'b0000;
          if (PACKET_DONE) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          control_q <= 4'b0000;
        end
      endcase
    end
  end

  assign count_ext = 8'(count_q);
  assign status    = {ovf_q, state_q, 2'b00, count_ext[2:0]};

  // Status is driven only while a STATUS read address is on the bus.
  assign BUS_DATA = rd_status ? status : 8'hzz;

  assign CAR     = car_q;
  assign CONTROL = control_q;
  assign BUSY    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ir_command_sequencer.sv
// Testbench for ir_command_sequencer: directed scenarios with literal
// expectations, then randomized bus/packet traffic against a queue-based
// model of the sequencer compared on every clock.
module tb_ir_command_sequencer;

  localparam logic [7:0] BASE  = 8'h90;
  localparam int         DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic       PACKET_DONE = 1'b0;
  logic [3:0] CAR;
  logic [3:0] CONTROL;
  logic       BUSY;
  logic [7:0] tb_data = 8'h00;
  logic       tb_drive = 1'b0;
  wire  [7:0] bus_data;

  assign bus_data = tb_drive ? tb_data : 8'hzz;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  ir_command_sequencer #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DUR_RESET (8'd4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_DATA   (bus_data),
    .BUS_WE     (BUS_WE),
    .PACKET_DONE(PACKET_DONE),
    .CAR        (CAR),
    .CONTROL    (CONTROL),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  logic [3:0] dir_tab [8] = '{4'b0000, 4'b0100, 4'b1000, 4'b0101,
                              4'b0110, 4'b1001, 4'b1010, 4'b0000};
  int         m_q[$];
  int         m_dur = 4;
  int         m_state = 0;   // 0 idle, 1 active, 2 stop
  int         m_left = 0;    // packets still to send for the current command
  logic [3:0] m_car = 4'b0001;
  logic [3:0] m_ctl = 4'b0000;
  bit         m_ovf = 1'b0;

  task automatic m_reset();
    m_q.delete();
    m_dur = 4; m_state = 0; m_left = 0;
    m_car = 4'b0001; m_ctl = 4'b0000; m_ovf = 1'b0;
  endtask

  task automatic m_start_next(input int dur);
    int v;
    v = m_q.pop_front();
    m_car = 4'(1 << ((v >> 3) & 3));
    m_ctl = dir_tab[v & 7];
    m_left = (dur == 0) ? 1 : dur;
    m_state = 1;
  endtask

  task automatic m_step();
    int  waiting;
    int  dur_now;
    bit  is_cmd, is_dur, is_ctrl;
    is_cmd  = BUS_WE && BUS_ADDR == BASE;
    is_dur  = BUS_WE && BUS_ADDR == BASE + 8'd1;
    is_ctrl = BUS_WE && BUS_ADDR == BASE + 8'd2;
    if (is_ctrl && tb_data[0]) begin
      m_q.delete(); m_ovf = 1'b0; m_state = 2; m_ctl = 4'b0000;
      return;
    end
    waiting = m_q.size();
    dur_now = m_dur;
    if (m_state == 0) begin
      if (waiting > 0) m_start_next(dur_now);
    end else if (m_state == 1) begin
      if (PACKET_DONE) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (waiting > 0) m_start_next(dur_now);
          else begin m_ctl = 4'b0000; m_state = 2; end
        end
      end
    end else begin
      if (PACKET_DONE) m_state = 0;
    end
    if (is_cmd) begin
      if (m_q.size() < DEPTH) m_q.push_back(int'(tb_data));
      else m_ovf = 1'b1;
    end
    if (is_dur) m_dur = int'(tb_data);
  endtask

  function automatic logic [7:0] m_status();
    logic [2:0] c;
    logic [1:0] s;
    c = 3'(m_q.size());
    s = 2'(m_state);
    return {m_ovf, s, 2'b00, c};
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) m_reset();
    else m_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Every clock, after the edge has settled, the outputs must match the model.
  always @(posedge CLK) begin
    #2;
    if (cmp_on) begin
      check("model_car", {4'h0, CAR}, {4'h0, m_car});
      check("model_control", {4'h0, CONTROL}, {4'h0, m_ctl});
      check("model_busy", {7'h0, BUSY}, {7'h0, (m_state != 0) || (m_q.size() != 0)});
      if (!BUS_WE && BUS_ADDR == BASE + 8'd2)
        check("model_status", bus_data, m_status());
    end
  end

  // ---------------- stimulus helpers (start and end at a negedge) ----------------
  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    BUS_ADDR = addr; BUS_WE = 1'b1; tb_data = data; tb_drive = 1'b1;
    $display("bus write addr=%02h data=%02h", addr, data);
    @(negedge CLK);
    BUS_WE = 1'b0; tb_drive = 1'b0; BUS_ADDR = 8'h00;
  endtask

  task automatic pd();
    PACKET_DONE = 1'b1;
    @(negedge CLK);
    PACKET_DONE = 1'b0;
  endtask

  task automatic read_status(input string name, input logic [7:0] exp);
    BUS_ADDR = BASE + 8'd2; BUS_WE = 1'b0; tb_drive = 1'b0;
    #1;
    $display("status read %s = %02h", name, bus_data);
    check(name, bus_data, exp);
    @(negedge CLK);
    BUS_ADDR = 8'h00;
  endtask

  task automatic check_out(input string name, input logic [3:0] car, input logic [3:0] ctl,
                           input logic busy);
    check({name, "_car"}, {4'h0, CAR}, {4'h0, car});
    check({name, "_control"}, {4'h0, CONTROL}, {4'h0, ctl});
    check({name, "_busy"}, {7'h0, BUSY}, {7'h0, busy});
  endtask

  initial begin
    int r;
    // Reset
    repeat (3) @(negedge CLK);
    check_out("reset", 4'b0001, 4'b0000, 1'b0);
    RESET = 1'b1;
    cmp_on = 1'b1;
    read_status("reset_status", 8'h00);

    // Single command: car 1, code 3, three packets, then one stop packet
    wr(BASE + 8'd1, 8'd3);
    wr(BASE, 8'h0B);
    @(negedge CLK);
    check_out("single_load", 4'b0010, 4'b0101, 1'b1);
    pd(); pd();
    check_out("single_hold", 4'b0010, 4'b0101, 1'b1);
    pd();
    check_out("single_stop", 4'b0010, 4'b0000, 1'b1);
    read_status("single_stop_status", 8'h40);
    pd();
    check_out("single_idle", 4'b0010, 4'b0000, 1'b0);

    // Back-to-back commands with no stop packet in between
    wr(BASE + 8'd1, 8'd2);
    wr(BASE, 8'h01);
    wr(BASE, 8'h02);
    check_out("b2b_first", 4'b0001, 4'b0100, 1'b1);
    pd();
    check_out("b2b_first_hold", 4'b0001, 4'b0100, 1'b1);
    pd();
    check_out("b2b_second", 4'b0001, 4'b1000, 1'b1);
    pd(); pd();
    check_out("b2b_stop", 4'b0001, 4'b0000, 1'b1);
    pd();
    check_out("b2b_idle", 4'b0001, 4'b0000, 1'b0);

    // Overflow while stalled in ACTIVE, then ABORT
    wr(BASE + 8'd1, 8'd4);
    wr(BASE, 8'h01);
    @(negedge CLK);
    wr(BASE, 8'h0A); wr(BASE, 8'h13); wr(BASE, 8'h1C); wr(BASE, 8'h05); wr(BASE, 8'h06);
    read_status("ovf_status", 8'hA4);
    check_out("ovf_active", 4'b0001, 4'b0100, 1'b1);
    wr(BASE + 8'd2, 8'h01);
    check_out("abort", 4'b0001, 4'b0000, 1'b1);
    read_status("abort_status", 8'h40);
    pd();
    read_status("abort_idle_status", 8'h00);

    // DURATION 0 acts as 1; code 7 sends a stop command while busy
    wr(BASE + 8'd1, 8'd0);
    wr(BASE, 8'h07);
    wr(BASE, 8'h19);
    check_out("code7", 4'b0001, 4'b0000, 1'b1);
    read_status("code7_status", 8'h21);
    pd();
    check_out("dur0_next", 4'b1000, 4'b0100, 1'b1);
    pd();
    read_status("dur0_stop_status", 8'h40);
    pd();
    check_out("dur0_idle", 4'b1000, 4'b0000, 1'b0);

    // Asynchronous reset in the middle of a command
    wr(BASE + 8'd1, 8'd5);
    wr(BASE, 8'h01);
    @(negedge CLK);
    check_out("pre_reset", 4'b0001, 4'b0100, 1'b1);
    #3 RESET = 1'b0;
    #1 check_out("async_reset", 4'b0001, 4'b0000, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    read_status("post_reset_status", 8'h00);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      PACKET_DONE = ($urandom_range(0, 99) < 35);
      BUS_WE = 1'b0; tb_drive = 1'b0; BUS_ADDR = 8'h00;
      if (r < 22) begin
        BUS_ADDR = BASE; BUS_WE = 1'b1; tb_drive = 1'b1; tb_data = 8'($urandom);
      end else if (r < 27) begin
        BUS_ADDR = BASE + 8'd1; BUS_WE = 1'b1; tb_drive = 1'b1;
        tb_data = 8'($urandom_range(0, 3));
      end else if (r < 29) begin
        BUS_ADDR = BASE + 8'd2; BUS_WE = 1'b1; tb_drive = 1'b1; tb_data = 8'($urandom);
      end else if (r < 45) begin
        BUS_ADDR = BASE + 8'd2;
      end else if (r < 47) begin
        BUS_ADDR = BASE + 8'd3; BUS_WE = 1'b1; tb_drive = 1'b1; tb_data = 8'($urandom);
      end
      if (BUS_WE)
        $display("rand cycle %0d write addr=%02h data=%02h pd=%0d", c, BUS_ADDR, tb_data, PACKET_DONE);
      if ($urandom_range(0, 599) == 0) begin
        $display("rand cycle %0d async reset", c);
        #2 RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    BUS_WE = 1'b0; tb_drive = 1'b0; BUS_ADDR = 8'h00; PACKET_DONE = 1'b0;
    repeat (2) @(negedge CLK);
    cmp_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_command_sequencer.md
# ir_command_sequencer

Bus-mapped scheduler that sits between the microprocessor bus and the IR transmitter. It queues up to four drive commands, and presents each one to the transmitter's car-select and CONTROL inputs for a programmable number of IR packets. After the queue drains, it sends exactly one stop packet. This replaces direct, untimed register writes to the transmitter, so software can issue timed manoeuvres without polling.

## Interface
- BASE_ADDR, 8'h90: base bus address. Registers are CMD at BASE+0, DURATION at BASE+1, CTRL/STATUS at BASE+2.
- FIFO_DEPTH, 4: command queue depth. Must be a power of two, ≤ 8.
- DUR_RESET, 8'd4: reset value of DURATION, in packets.

Ports:
- CLK  in  1  system clock. Single clock domain.
- RESET  in  1  asynchronous, active-low reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA  inout  8  bus data. Driven only during a STATUS read, high-Z otherwise.
- BUS_WE  in  1  bus write enable. 1 = write, 0 = read.
- PACKET_DONE  in  1  one-cycle pulse from the transmitter at the end of each packet.
- CAR  out  4  one-hot car select {RED, GREEN, YELLOW, BLUE}, from bit 3 down to bit 0.
- CONTROL  out  4  drive bits {BACK, FWD, LEFT, RIGHT}, from bit 3 down to bit 0.
- BUSY  out  1  high when the state is not IDLE or the FIFO is non-empty.

## Operation
- **CMD write (BASE+0):** the byte is pushed to the FIFO.
  - bits[2:0] = direction code; bits[4:3] = car (0 blue, 1 yellow, 2 green, 3 red); bits[7:5] ignored.
  - If the FIFO is full, the write is dropped and the sticky OVF flag is set.
- **DURATION write (BASE+1):** sets the packets-per-command count. A value of 0 is treated as 1. The new value takes effect at the next command load.
- **CTRL write (BASE+2):** bit0 = ABORT. ABORT flushes the FIFO, clears OVF and forces the STOP state. Other bits are ignored.
- **STATUS read (BASE+2, BUS_WE=0):** returns {OVF, state[1:0], 2'b0, count[2:0]}. State encoding: IDLE=0, ACTIVE=1, STOP=2.
- **Direction decode** (CONTROL value):
  - 1 → 0100 (forward)
  - 2 → 1000 (back)
  - 3 → 0101 (forward right)
  - 4 → 0110 (forward left)
  - 5 → 1001 (back right)
  - 6 → 1010 (back left)
  - 0 and 7 → 0000 (stop)
- **FSM:**
  - IDLE: CONTROL=0. If the FIFO is non-empty, pop the head, register CAR and CONTROL, load remain=DURATION (0→1), and go to ACTIVE.
  - ACTIVE: each PACKET_DONE decrements remain. On PACKET_DONE with remain==1:
    - If the FIFO is non-empty, pop the next command and reload remain, staying in ACTIVE (back-to-back, no stop packet in between).
    - Otherwise set CONTROL=0 and go to STOP.
  - STOP: CONTROL=0 and CAR is held. On PACKET_DONE, go to IDLE.
- **Simultaneous events:**
  - CMD write and pop in the same cycle: both happen. Count is unchanged, and a write to a full FIFO succeeds in that cycle.
  - ABORT has priority over everything, including a pop or PACKET_DONE in the same cycle.
  - A CMD write in the same cycle as ABORT is discarded.
- **Reset state:** CONTROL=0, CAR=4'b0001, BUSY=0, FIFO empty, OVF=0, DURATION=DUR_RESET, state IDLE, BUS_DATA high-Z. Reset is asynchronous and may occur mid-command, returning everything to these values immediately.

## Timing
- Register writes are captured on the CLK edge where BUS_ADDR matches and BUS_WE=1.
- CMD latency: write captured at edge n, pop at edge n+1, so CAR and CONTROL are valid after edge n+1 when the block was IDLE.
- CONTROL and CAR change only at a load, at STOP entry, or on ABORT. They are stable between PACKET_DONE pulses.
- A command lasts exactly DURATION PACKET_DONE pulses. CONTROL updates on the edge that samples the final pulse.
- BUS_DATA is driven combinationally while a STATUS read address is present.
- FIFO count wraps on a power-of-two pointer. count ranges 0..FIFO_DEPTH and never wraps past full.
- PACKET_DONE in IDLE is ignored.

## Test plan
- **Reset:** hold RESET=0 mid-ACTIVE → CONTROL=0, CAR=0001, BUSY=0, and STATUS reads 8'h00 after release.
- **Single command:** DURATION=3, CMD=8'h0B (car 1, code 3) → CAR=0010 and CONTROL=0101 one cycle after the write. It holds for 3 PACKET_DONE pulses, then CONTROL=0000 for one packet, then IDLE with BUSY=0.
- **Back-to-back:** queue 8'h01 then 8'h02 with DURATION=2 → CONTROL=0100 for 2 packets, then 1000 for 2 packets with no 0000 between them, then one stop packet.
- **Overflow:** 5 CMD writes while ACTIVE is stalled (no PACKET_DONE) → count=4, STATUS bit7=1, and the fifth command is never executed.
- **Abort:** ABORT while ACTIVE with 3 queued → next cycle count=0, OVF=0, state STOP, CONTROL=0000. The next PACKET_DONE returns to IDLE.
- **Edge values:** DURATION=0 → each command lasts 1 packet. Code 7 (8'h07) → CONTROL=0000 for DURATION packets while BUSY=1.
